// File: rtl/lut_train_pkg.sv
// Shared types and default sizes for the Boolean lookup-table training scheduler.
package lut_train_pkg;

  localparam int N_IN_DEF  = 4;
  localparam int DEPTH_DEF = 16;
  localparam int AW_DEF    = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_TRAIN,
    S_CHECK,
    S_EVAL,
    S_DONE
  } state_e;

  typedef struct packed {
    logic                y;
    logic [N_IN_DEF-1:0] x;
  } sample_t;

endpackage

// File: rtl/lut_sample_buf.sv
// Sample register file: DEPTH x W, one synchronous write port, one asynchronous read port.
module lut_sample_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0]  wd,
  input  logic [AW-1:0] ra,
  output logic [W-1:0]  rd
);

  logic [W-1:0] mem_q [DEPTH];

  // NOTE: the storage has no reset; samples survive rst and only the write port changes them.
  always_ff @(posedge clk) begin
    if (we && (int'(wa) < DEPTH)) begin
      mem_q[wa] <= wd;
    end
  end

  assign rd = mem_q[ra];

endmodule

// File: rtl/lut_train_sched.sv
// Training scheduler for the single-layer LUT learner: runs epochs over the sample buffer.
// Optional post-training evaluation pass is enabled by defining LUT_SCHED_EVAL_EN.
module lut_train_sched
  import lut_train_pkg::*;
#(
  parameter int N_IN       = N_IN_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int AW         = AW_DEF,
  parameter int EPOCH_W    = 8,
  parameter int MAX_EPOCHS = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [N_IN:0]      wr_data,
  input  logic [AW:0]        num_samples,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               converged,
  output logic [EPOCH_W-1:0] epoch_count,
  output logic [AW:0]        err_count,
  output logic               lrn_clr,
  output logic               lrn_en,
  output logic [N_IN-1:0]    lrn_x,
  output logic               lrn_y,
  input  logic               lrn_pred
`ifdef LUT_SCHED_EVAL_EN
  , output logic [AW:0]      eval_err
`endif
);

  localparam logic [AW:0]        DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [EPOCH_W-1:0] MAX_W   = EPOCH_W'(MAX_EPOCHS);

  state_e             state_q, state_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [AW:0]        acc_q, acc_d;
  logic [AW:0]        ns_q, ns_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic [AW:0]        err_q, err_d;
  logic               conv_q, conv_d;
  logic [N_IN:0]      rd_data;
  logic               mis, last, start_ok;
`ifdef LUT_SCHED_EVAL_EN
  logic [AW:0]        eval_q, eval_d;
`endif

  lut_sample_buf #(.DEPTH(DEPTH), .AW(AW), .W(N_IN+1)) u_buf (
    .clk (clk),
    .we  (wr_en && !busy),
    .wa  (wr_addr),
    .wd  (wr_data),
    .ra  (addr_q),
    .rd  (rd_data)
  );

  assign lrn_x    = rd_data[N_IN-1:0];
  assign lrn_y    = rd_data[N_IN];
  assign mis      = lrn_pred ^ lrn_y;
  assign last     = ({1'b0, addr_q} == (ns_q - (AW+1)'(1)));
  assign start_ok = (num_samples != '0) && (num_samples <= DEPTH_W);

  always_comb begin
    // NOTE: every _d defaults to its held value so no path through the case infers a latch.
    state_d = state_q;
    addr_d  = addr_q;
    acc_d   = acc_q;
    ns_d    = ns_q;
    epoch_d = epoch_q;
    err_d   = err_q;
    conv_d  = conv_q;
`ifdef LUT_SCHED_EVAL_EN
    eval_d  = eval_q;
`endif
    if (abort && busy) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start && !abort && start_ok) begin
            ns_d    = num_samples;
            epoch_d = '0;
            err_d   = '0;
            conv_d  = 1'b0;
`ifdef LUT_SCHED_EVAL_EN
            eval_d  = '0;
`endif
            state_d = S_CLEAR;
          end
        end
        S_CLEAR: begin
          addr_d  = '0;
          acc_d   = '0;
          state_d = S_TRAIN;
        end
        S_TRAIN: begin
          if (mis) acc_d = acc_q + (AW+1)'(1);
          if (last) state_d = S_CHECK;
          else      addr_d  = addr_q + AW'(1);
        end
        S_CHECK: begin
          err_d   = acc_q;
          epoch_d = epoch_q + EPOCH_W'(1);
          addr_d  = '0;
          acc_d   = '0;
          if (acc_q == '0 || (epoch_q + EPOCH_W'(1)) == MAX_W) begin
            conv_d = (acc_q == '0);
`ifdef LUT_SCHED_EVAL_EN
            state_d = S_EVAL;
`else
            state_d = S_DONE;
`endif
          end else begin
            state_d = S_TRAIN;
          end
        end
`ifdef LUT_SCHED_EVAL_EN
        S_EVAL: begin
          if (mis) acc_d = acc_q + (AW+1)'(1);
          if (last) begin
            eval_d  = acc_q + (AW+1)'(mis);
            state_d = S_DONE;
          end else begin
            addr_d = addr_q + AW'(1);
          end
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      acc_q   <= '0;
      ns_q    <= '0;
      epoch_q <= '0;
      err_q   <= '0;
      conv_q  <= 1'b0;
`ifdef LUT_SCHED_EVAL_EN
      eval_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      acc_q   <= acc_d;
      ns_q    <= ns_d;
      epoch_q <= epoch_d;
      err_q   <= err_d;
      conv_q  <= conv_d;
`ifdef LUT_SCHED_EVAL_EN
      eval_q  <= eval_d;
`endif
    end
  end

  assign busy        = (state_q == S_CLEAR) || (state_q == S_TRAIN) ||
                       (state_q == S_CHECK) || (state_q == S_EVAL);
  assign done        = (state_q == S_DONE);
  assign lrn_clr     = (state_q == S_CLEAR);
  assign lrn_en      = (state_q == S_TRAIN);
  assign converged   = conv_q;
  assign epoch_count = epoch_q;
  assign err_count   = err_q;
`ifdef LUT_SCHED_EVAL_EN
  assign eval_err    = eval_q;
`endif

endmodule

// File: tb/tb_lut_train_sched.sv
// Self-checking bench for lut_train_sched with a behavioural LUT learner and epoch-level model.
module tb_lut_train_sched;
  import lut_train_pkg::*;

  localparam int MAXE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [4:0] wr_data = '0;
  logic [4:0] num_samples = '0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       busy, done, converged, lrn_clr, lrn_en, lrn_y, lrn_pred;
  logic [7:0] epoch_count;
  logic [4:0] err_count;
  logic [3:0] lrn_x;
`ifdef LUT_SCHED_EVAL_EN
  logic [4:0] eval_err;
`endif

  lut_train_sched #(.MAX_EPOCHS(MAXE)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .num_samples(num_samples), .start(start), .abort(abort), .busy(busy), .done(done),
    .converged(converged), .epoch_count(epoch_count), .err_count(err_count),
    .lrn_clr(lrn_clr), .lrn_en(lrn_en), .lrn_x(lrn_x), .lrn_y(lrn_y), .lrn_pred(lrn_pred)
`ifdef LUT_SCHED_EVAL_EN
    , .eval_err(eval_err)
`endif
  );

  always #5 clk = ~clk;

  // Learner: table entry takes the presented label on every enabled cycle.
  logic [15:0] tbl = '0;
  always @(posedge clk) begin
    if (lrn_clr)     tbl <= '0;
    else if (lrn_en) tbl[lrn_x] <= lrn_y;
  end
  assign lrn_pred = tbl[lrn_x];

  int clr_cnt = 0;
  always @(negedge clk) if (lrn_clr === 1'b1) clr_cnt++;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference: the epoch loop over the buffer image, at the level of whole epochs.
  sample_t ref_mem [16];
  int      exp_errs[$];
  int      exp_epochs, exp_eval;
  bit      exp_conv;

  function automatic void ref_run(input int n);
    bit t [16];
    int e;
    foreach (t[i]) t[i] = 1'b0;
    exp_errs.delete();
    exp_epochs = 0;
    exp_conv   = 1'b0;
    while (1) begin
      e = 0;
      for (int i = 0; i < n; i++) begin
        if (t[ref_mem[i].x] != ref_mem[i].y) e++;
        t[ref_mem[i].x] = ref_mem[i].y;
      end
      exp_errs.push_back(e);
      exp_epochs++;
      if (e == 0) begin exp_conv = 1'b1; break; end
      if (exp_epochs == MAXE) break;
    end
    exp_eval = 0;
    for (int i = 0; i < n; i++) if (t[ref_mem[i].x] != ref_mem[i].y) exp_eval++;
  endfunction

  task automatic wr(input int a, input logic y, input logic [3:0] x);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'(a); wr_data = sample_t'{y, x};
    ref_mem[a] = sample_t'{y, x};
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_start(input int n);
    @(negedge clk);
    num_samples = 5'(n); start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  int last_cycles;

  // Full run; poke_at >= 0 issues a stray write to slot 0 in that cycle of the run.
  task automatic run(input string tag, input int n, input int poke_at);
    int cyc, last_ep, clr0, ncmp, exp_cyc;
    int got_errs[$];
    ref_run(n);
    clr0 = clr_cnt;
    pulse_start(n);
    cyc = 0; last_ep = 0;
    while (done !== 1'b1 && cyc < 3000) begin
      wr_en = (cyc == poke_at); wr_addr = '0; wr_data = sample_t'{1'b1, 4'd0};
      @(posedge clk); cyc++;
      @(negedge clk);
      if (int'(epoch_count) != last_ep) begin
        got_errs.push_back(int'(err_count));
        last_ep = int'(epoch_count);
      end
    end
    wr_en = 1'b0;
    last_cycles = cyc;
    exp_cyc = 1 + exp_epochs * (n + 1);
`ifdef LUT_SCHED_EVAL_EN
    exp_cyc += n;
    check({tag, ":eval_err"}, eval_err, exp_eval);
`endif
    check({tag, ":done"}, done, 1);
    check({tag, ":cycles"}, cyc, exp_cyc);
    check({tag, ":converged"}, converged, exp_conv);
    check({tag, ":epochs"}, epoch_count, exp_epochs);
    check({tag, ":busy"}, busy, 0);
    check({tag, ":clr_pulses"}, clr_cnt - clr0, 1);
    check({tag, ":n_epoch_reports"}, got_errs.size(), exp_errs.size());
    ncmp = (got_errs.size() < exp_errs.size()) ? got_errs.size() : exp_errs.size();
    for (int i = 0; i < ncmp; i++) check($sformatf("%s:err_ep%0d", tag, i + 1), got_errs[i], exp_errs[i]);
  endtask

  initial begin
    foreach (ref_mem[i]) ref_mem[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    check("rst:busy", busy, 0);
    check("rst:done", done, 0);
    check("rst:converged", converged, 0);
    check("rst:lrn_clr", lrn_clr, 0);
    check("rst:lrn_en", lrn_en, 0);
    check("rst:epoch", epoch_count, 0);
    check("rst:err", err_count, 0);
`ifdef LUT_SCHED_EVAL_EN
    check("rst:eval_err", eval_err, 0);
`endif

    // Illegal sample counts and start+abort collision are all ignored in IDLE.
    pulse_start(0);  repeat (2) @(negedge clk);
    check("ns0:busy", busy, 0);
    pulse_start(17); repeat (2) @(negedge clk);
    check("ns17:busy", busy, 0);
    @(negedge clk) abort = 1'b1;
    pulse_start(16); abort = 1'b0; repeat (2) @(negedge clk);
    check("start_abort:busy", busy, 0);
    check("reject:clr_pulses", clr_cnt, 0);
    check("reject:done", done, 0);

    // Separable set: y = x[0].
    for (int i = 0; i < 16; i++) wr(i, 1'(i), 4'(i));
    run("sep", 16, -1);
`ifdef LUT_SCHED_EVAL_EN
    check("sep:cycles_lit", last_cycles, 51);
`else
    check("sep:cycles_lit", last_cycles, 35);
`endif
    check("sep:err_last", err_count, 0);

    // Contradictory pair hits the epoch limit.
    wr(0, 1'b0, 4'd3);
    wr(1, 1'b1, 4'd3);
    run("contra", 2, -1);
    check("contra:cycles_lit", last_cycles, 1 + MAXE * 3 + `ifdef LUT_SCHED_EVAL_EN 2 `else 0 `endif);

    // Abort in the 5th TRAIN cycle of epoch 2, then restart from IDLE.
    wr(0, 1'b0, 4'd0);
    wr(1, 1'b1, 4'd1);
    pulse_start(16);
    repeat (22) @(posedge clk);
    @(negedge clk);
    check("abort:in_train", lrn_en, 1);
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    check("abort:busy", busy, 0);
    check("abort:done", done, 0);
    check("abort:lrn_en", lrn_en, 0);
    check("abort:epoch_held", epoch_count, 1);
    check("abort:err_held", err_count, 8);
    run("rerun", 16, -1);

    // Stray write during TRAIN must be dropped.
    run("poke", 16, 3);

    // Randomised sample sets; small x ranges provoke contradictions.
    for (int r = 0; r < 8; r++) begin
      int n, xmax;
      n = int'($urandom_range(1, 16));
      xmax = (r % 2 == 0) ? 15 : 3;
      for (int i = 0; i < n; i++) wr(i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, xmax)));
      run($sformatf("rnd%0d", r), n, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
